// File: rtl/memory_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory instance.
// The arbiter connects through the slave modport; requesters/memory through master.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    logic [DATA_W-1:0] rdata_o;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_read_data,
        output gnt_o, done_o, rdata_o, mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_read_data,
        input  gnt_o, done_o, rdata_o, mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the core (port 0)
// and the debug/DMA loader (port 1). One access in flight; done pulses after
// the fixed memory latency.
module memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    memory_arbiter_if.slave bus
);
    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;
    logic              r_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_any;
    logic              w_win;

    // Winner selection: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_any = |bus.req_i;
        if (&bus.req_i) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = bus.req_i[1];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the granted access and count latency cycles while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_last_grant <= w_win;
            r_winner     <= w_win;
            r_we         <= bus.we_i[w_win];
            r_addr       <= w_win ? bus.addr1_i : bus.addr0_i;
            r_wdata      <= w_win ? bus.wdata1_i : bus.wdata0_i;
            r_cnt        <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next state and outputs; reset forces every output low without waiting for a clock
    always_comb begin
        w_next_state         = r_state;
        bus.gnt_o            = '0;
        bus.done_o           = '0;
        bus.rdata_o          = '0;
        bus.mem_address      = r_addr;
        bus.mem_write_data   = r_wdata;
        bus.mem_write_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.mem_address    = '0;
                bus.mem_write_data = '0;
                if (w_any) begin
                    bus.gnt_o            = w_win ? 2'b10 : 2'b01;
                    bus.mem_address      = w_win ? bus.addr1_i : bus.addr0_i;
                    bus.mem_write_data   = w_win ? bus.wdata1_i : bus.wdata0_i;
                    bus.mem_write_enable = bus.we_i[w_win];
                    w_next_state         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                bus.done_o   = r_winner ? 2'b10 : 2'b01;
                bus.rdata_o  = r_we ? '0 : bus.mem_read_data;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (reset) begin
            bus.gnt_o            = '0;
            bus.done_o           = '0;
            bus.rdata_o          = '0;
            bus.mem_address      = '0;
            bus.mem_write_data   = '0;
            bus.mem_write_enable = 1'b0;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance with MEM_LATENCY=1 and one
// with MEM_LATENCY=3, each attached to a small memory model.
module tb_memory_arbiter;
    logic clk;
    logic rst1;
    logic rst3;
    int   n_err;
    int   n_checks;

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_arb1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.slave)
    );

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_arb3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: word index = byte address [7:2]
    logic [31:0] mem1 [64] = '{40: 32'hbadab00f, 42: 32'hdeadbeef, default: 32'h0};
    logic [31:0] mem3 [64] = '{40: 32'hbadab00f, 42: 32'hdeadbeef, default: 32'h0};
    logic [31:0] rd1;
    logic [31:0] p3a;
    logic [31:0] p3b;
    logic [31:0] p3c;

    always @(posedge clk) begin
        if (if1.mem_write_enable) mem1[if1.mem_address[7:2]] <= if1.mem_write_data;
        rd1 <= mem1[if1.mem_address[7:2]];
    end

    always @(posedge clk) begin
        if (if3.mem_write_enable) mem3[if3.mem_address[7:2]] <= if3.mem_write_data;
        p3a <= mem3[if3.mem_address[7:2]];
        p3b <= p3a;
        p3c <= p3b;
    end

    assign if1.mem_read_data = rd1;
    assign if3.mem_read_data = p3c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and drive the L=1 instance mid-cycle; checks follow at edge+4
    task automatic step1(input logic [1:0] req, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1);
        @(posedge clk);
        #2;
        if1.req_i = req; if1.we_i = we; if1.addr0_i = a0; if1.addr1_i = a1;
        if1.wdata0_i = w0; if1.wdata1_i = w1;
        #2;
    endtask

    task automatic step3(input logic [1:0] req, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1);
        @(posedge clk);
        #2;
        if3.req_i = req; if3.we_i = we; if3.addr0_i = a0; if3.addr1_i = a1;
        if3.wdata0_i = w0; if3.wdata1_i = w1;
        #2;
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        if1.req_i = '0; if1.we_i = '0; if1.addr0_i = '0; if1.addr1_i = '0;
        if1.wdata0_i = '0; if1.wdata1_i = '0;
        if3.req_i = '0; if3.we_i = '0; if3.addr0_i = '0; if3.addr1_i = '0;
        if3.wdata0_i = '0; if3.wdata1_i = '0;

        // Reset state: outputs low even with both ports requesting
        step1(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("rst_gnt", if1.gnt_o, 2'b00);
        chk("rst_done", if1.done_o, 2'b00);
        chk("rst_we", if1.mem_write_enable, 1'b0);
        chk("rst_addr", if1.mem_address, 32'h0);
        chk("rst_rdata", if1.rdata_o, 32'h0);
        if1.req_i = 2'b00;
        rst1 = 1'b0;
        rst3 = 1'b0;

        // 1. Single read, L=1
        step1(2'b01, 2'b00, 32'ha8, 32'h0, 32'h0, 32'h0);
        chk("t1_gnt", if1.gnt_o, 2'b01);
        chk("t1_addr", if1.mem_address, 32'ha8);
        chk("t1_we", if1.mem_write_enable, 1'b0);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t1_wait_gnt", if1.gnt_o, 2'b00);
        chk("t1_wait_done", if1.done_o, 2'b00);
        chk("t1_hold_addr", if1.mem_address, 32'ha8);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t1_done", if1.done_o, 2'b01);
        chk("t1_rdata", if1.rdata_o, 32'hdeadbeef);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t1_idle_done", if1.done_o, 2'b00);

        // 2. Single write from port 1, L=1
        step1(2'b10, 2'b10, 32'h0, 32'hac, 32'h0, 32'hcafebabe);
        chk("t2_gnt", if1.gnt_o, 2'b10);
        chk("t2_we", if1.mem_write_enable, 1'b1);
        chk("t2_addr", if1.mem_address, 32'hac);
        chk("t2_wdata", if1.mem_write_data, 32'hcafebabe);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t2_wait_we", if1.mem_write_enable, 1'b0);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t2_done", if1.done_o, 2'b10);
        chk("t2_rdata", if1.rdata_o, 32'h0);
        chk("t2_mem", mem1[43], 32'hcafebabe);

        // 3. Contention straight after reset: port 0 first, port 1 re-arbitrated in IDLE
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rst1 = 1'b1;
        #1;
        rst1 = 1'b0;
        step1(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("t3_gnt0", if1.gnt_o, 2'b01);
        chk("t3_addr0", if1.mem_address, 32'ha0);
        step1(2'b10, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("t3_ignored", if1.gnt_o, 2'b00);
        step1(2'b10, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("t3_done0", if1.done_o, 2'b01);
        chk("t3_rdata0", if1.rdata_o, 32'hbadab00f);
        chk("t3_done_gnt", if1.gnt_o, 2'b00);
        step1(2'b10, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("t3_gnt1", if1.gnt_o, 2'b10);
        chk("t3_addr1", if1.mem_address, 32'ha8);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t3_done1", if1.done_o, 2'b10);
        chk("t3_rdata1", if1.rdata_o, 32'hdeadbeef);

        // 4. Fairness: both ports request continuously, grants alternate from port 0
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            step1(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
            chk($sformatf("t4_gnt%0d", i), if1.gnt_o, exp_g);
            step1(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
            chk($sformatf("t4_wait%0d", i), if1.gnt_o, 2'b00);
            step1(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
            chk($sformatf("t4_done%0d", i), if1.done_o, exp_g);
        end

        // 5. Reset during WAIT of a port 0 read drops the access
        step1(2'b01, 2'b00, 32'ha8, 32'h0, 32'h0, 32'h0);
        chk("t5_gnt", if1.gnt_o, 2'b01);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rst1 = 1'b1;
        #1;
        chk("t5_rst_gnt", if1.gnt_o, 2'b00);
        chk("t5_rst_done", if1.done_o, 2'b00);
        chk("t5_rst_addr", if1.mem_address, 32'h0);
        chk("t5_rst_we", if1.mem_write_enable, 1'b0);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rst1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            chk($sformatf("t5_nodone%0d", k), if1.done_o, 2'b00);
        end
        step1(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("t5_regrant", if1.gnt_o, 2'b01);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t5_done", if1.done_o, 2'b01);
        chk("t5_rdata", if1.rdata_o, 32'hbadab00f);

        // 6. Port 1 pulses a write request while port 0 is busy, then withdraws it
        step1(2'b01, 2'b00, 32'ha0, 32'h0, 32'h0, 32'h0);
        chk("t6_gnt", if1.gnt_o, 2'b01);
        step1(2'b10, 2'b10, 32'ha0, 32'hac, 32'h0, 32'h11111111);
        chk("t6_wait_gnt", if1.gnt_o, 2'b00);
        chk("t6_wait_we", if1.mem_write_enable, 1'b0);
        step1(2'b10, 2'b10, 32'ha0, 32'hac, 32'h0, 32'h11111111);
        chk("t6_done", if1.done_o, 2'b01);
        chk("t6_done_gnt", if1.gnt_o, 2'b00);
        chk("t6_rdata", if1.rdata_o, 32'hbadab00f);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t6_idle_gnt", if1.gnt_o, 2'b00);
        chk("t6_idle_we", if1.mem_write_enable, 1'b0);
        step1(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t6_mem", mem1[43], 32'hcafebabe);

        // 1 with L=3: done at T+4
        step3(2'b01, 2'b00, 32'ha8, 32'h0, 32'h0, 32'h0);
        chk("l3_t1_gnt", if3.gnt_o, 2'b01);
        chk("l3_t1_addr", if3.mem_address, 32'ha8);
        for (int k = 0; k < 3; k++) begin
            step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            chk($sformatf("l3_t1_wait%0d", k), if3.done_o, 2'b00);
        end
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("l3_t1_done", if3.done_o, 2'b01);
        chk("l3_t1_rdata", if3.rdata_o, 32'hdeadbeef);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("l3_t1_idle", if3.done_o, 2'b00);

        // 2 with L=3
        step3(2'b10, 2'b10, 32'h0, 32'hac, 32'h0, 32'hcafebabe);
        chk("l3_t2_gnt", if3.gnt_o, 2'b10);
        chk("l3_t2_we", if3.mem_write_enable, 1'b1);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("l3_t2_wait_we", if3.mem_write_enable, 1'b0);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("l3_t2_early", if3.done_o, 2'b00);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("l3_t2_done", if3.done_o, 2'b10);
        chk("l3_t2_rdata", if3.rdata_o, 32'h0);
        chk("l3_t2_mem", mem3[43], 32'hcafebabe);

        // 5 with L=3: reset in the middle of WAIT
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step3(2'b01, 2'b00, 32'ha8, 32'h0, 32'h0, 32'h0);
        chk("l3_t5_gnt", if3.gnt_o, 2'b01);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rst3 = 1'b1;
        #1;
        chk("l3_t5_rst_addr", if3.mem_address, 32'h0);
        chk("l3_t5_rst_done", if3.done_o, 2'b00);
        step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rst3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step3(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            chk($sformatf("l3_t5_nodone%0d", k), if3.done_o, 2'b00);
        end
        step3(2'b11, 2'b00, 32'ha0, 32'ha8, 32'h0, 32'h0);
        chk("l3_t5_regrant", if3.gnt_o, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
